// File: rtl/argmax_pkg.sv
// Shared types and constants for the classification-stage argmax sequencer.
// slot_of() extracts score k from the packed comparator vector (slot 0 in the MSBs).
package argmax_pkg;

   localparam int NUM_CLASS = 10;
   localparam int DATA_W    = 16;
   localparam int BUF_W     = 160;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      COMPARE = 2'd1,
      HOLD    = 2'd2
   } argmax_state_e;

   typedef logic signed [DATA_W-1:0] score_t;

   function automatic score_t slot_of(input logic [BUF_W-1:0] vec, input int unsigned k);
      return score_t'(vec[BUF_W-1-DATA_W*k -: DATA_W]);
   endfunction

endpackage

// File: rtl/argmax_sched_compare.sv
// Combinational argmax over the ten packed signed scores; slot k is class 10-k.
// Only a strictly greater score replaces the current best, so ties keep the earliest slot.
module compare_result
   import argmax_pkg::*;
(
   input  logic [BUF_W-1:0] vec_i,
   output logic [31:0]      class_o
);

   score_t      best_s;
   logic [31:0] class_s;

   // scan slots in arrival order, keeping the first maximum seen
   always_comb begin
      best_s  = slot_of(vec_i, 0);
      class_s = 32'(NUM_CLASS);
      for (int k = 1; k < NUM_CLASS; k++) begin
         if (slot_of(vec_i, k) > best_s) begin
            best_s  = slot_of(vec_i, k);
            class_s = 32'(NUM_CLASS - k);
         end else begin
            class_s = class_s;
         end
      end
   end

   assign class_o = class_s;

endmodule

// File: rtl/argmax_sched.sv
// Collects one frame of class scores, runs the argmax comparator in a registered
// cycle and holds the winning class/score on a valid/ready result port.
module argmax_sched #(
   parameter int NUM_CLASS = 10,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              score_valid,
   output logic              score_ready,
   input  logic [DATA_W-1:0] score_data,
   input  logic              score_last,
   input  logic              flush,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [31:0]       result_class,
   output logic [DATA_W-1:0] result_max,
   output logic              frame_err,
   output logic [15:0]       frame_cnt
);

   import argmax_pkg::*;

   localparam logic [3:0] LAST_SLOT = 4'(NUM_CLASS - 1);

   argmax_state_e     state_q, state_d;
   logic [3:0]        slot_cnt_q, slot_cnt_d;
   logic [BUF_W-1:0]  buf_q, buf_d;
   logic              result_valid_q, result_valid_d;
   logic [31:0]       result_class_q, result_class_d;
   logic [DATA_W-1:0] result_max_q, result_max_d;
   logic              frame_err_q, frame_err_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [31:0]       cmp_class_s;
   logic              score_hs_s;

   compare_result u_compare (
      .vec_i   (buf_q),
      .class_o (cmp_class_s)
   );

   assign score_hs_s = score_valid && (state_q == COLLECT);

   // next-state logic; flush wins over any handshake in the same cycle
   always_comb begin
      state_d        = state_q;
      slot_cnt_d     = slot_cnt_q;
      buf_d          = buf_q;
      result_valid_d = result_valid_q;
      result_class_d = result_class_q;
      result_max_d   = result_max_q;
      frame_err_d    = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      if (flush) begin
         state_d        = COLLECT;
         slot_cnt_d     = 4'd0;
         result_valid_d = 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (score_hs_s) begin
                  buf_d[BUF_W-1-DATA_W*int'(slot_cnt_q) -: DATA_W] = score_data;
                  if ((slot_cnt_q == LAST_SLOT) && score_last) begin
                     state_d    = COMPARE;
                     slot_cnt_d = 4'd0;
                  end else if ((slot_cnt_q == LAST_SLOT) || score_last) begin
                     frame_err_d = 1'b1;
                     slot_cnt_d  = 4'd0;
                  end else begin
                     slot_cnt_d = slot_cnt_q + 4'd1;
                  end
               end else begin
                  slot_cnt_d = slot_cnt_q;
               end
            end
            COMPARE: begin
               result_class_d = cmp_class_s;
               result_max_d   = slot_of(buf_q, 32'(NUM_CLASS) - cmp_class_s);
               result_valid_d = 1'b1;
               state_d        = HOLD;
            end
            HOLD: begin
               if (result_ready) begin
                  state_d        = COLLECT;
                  result_valid_d = 1'b0;
                  frame_cnt_d    = frame_cnt_q + 16'd1;
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d        = COLLECT;
               slot_cnt_d     = 4'd0;
               result_valid_d = 1'b0;
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= COLLECT;
         slot_cnt_q     <= 4'd0;
         buf_q          <= '0;
         result_valid_q <= 1'b0;
         result_class_q <= 32'd0;
         result_max_q   <= '0;
         frame_err_q    <= 1'b0;
         frame_cnt_q    <= 16'd0;
      end else begin
         state_q        <= state_d;
         slot_cnt_q     <= slot_cnt_d;
         buf_q          <= buf_d;
         result_valid_q <= result_valid_d;
         result_class_q <= result_class_d;
         result_max_q   <= result_max_d;
         frame_err_q    <= frame_err_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

   assign score_ready  = (state_q == COLLECT);
   assign result_valid = result_valid_q;
   assign result_class = result_class_q;
   assign result_max   = result_max_q;
   assign frame_err    = frame_err_q;
   assign frame_cnt    = frame_cnt_q;

endmodule
